// File: rtl/mcc_run_sequencer.sv
// Run controller for the multi-cycle computer: holds the CPU in reset, runs it for a bounded
// budget, captures its program output into a trace FIFO and stops early when the output stalls.
module mcc_run_sequencer #(
  parameter int WIDTH             = 16,
  parameter int RESET_CYCLES      = 5,
  parameter int RUN_CYCLES        = 296,
  parameter int DEPTH             = 64,
  parameter int STALL_LIMIT       = 8,
  parameter int CAPTURE_ON_CHANGE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         prog_out,
  output logic                     dut_reset,
  output logic                     dut_run,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [15:0]              cycles_run,
  output logic                     busy,
  output logic                     done,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t            state, state_next;
  logic [31:0]       hold_cnt;
  logic [31:0]       budget_cnt;
  logic [31:0]       stall_cnt;
  logic [31:0]       stall_next;
  logic              first_sample;
  logic [WIDTH-1:0]  prev_sample;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic sample_same, halt_hit, last_sample, want_wr, flush, full, do_rd, do_wr;

  assign sample_same = !first_sample && (prog_out == prev_sample);
  assign stall_next  = !sample_same     ? 32'd0 :
                       (stall_cnt == '1) ? stall_cnt : stall_cnt + 32'd1;
  assign halt_hit    = (STALL_LIMIT != 0) && (stall_next == 32'(STALL_LIMIT));
  assign last_sample = (budget_cnt == 32'(RUN_CYCLES - 1));

  // With change capture, the first sample of a sequence always goes in; repeats are skipped.
  assign want_wr = (state == S_RUN) && ((CAPTURE_ON_CHANGE == 0) || !sample_same);
  assign flush   = start && ((state == S_IDLE) || (state == S_DONE));
  assign full    = (trace_count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && (trace_count != '0) && !flush;
  assign do_wr   = want_wr && (!full || do_rd);

  assign busy = (state == S_HOLD) || (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    dut_reset  = 1'b1;
    dut_run    = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_HOLD;
      S_HOLD: if (hold_cnt == 32'(RESET_CYCLES - 1)) state_next = S_RUN;
      S_RUN: begin
        dut_reset = 1'b0;
        dut_run   = 1'b1;
        if (halt_hit || last_sample) state_next = S_DONE;
      end
      S_DONE: begin
        dut_reset = 1'b0;
        if (start) state_next = S_HOLD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      budget_cnt   <= '0;
      stall_cnt    <= '0;
      first_sample <= 1'b1;
      prev_sample  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      trace_count  <= '0;
      overflow     <= 1'b0;
      cycles_run   <= '0;
      halted       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      state    <= state_next;
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[rd_ptr];

      if (flush) begin
        hold_cnt     <= '0;
        budget_cnt   <= '0;
        stall_cnt    <= '0;
        first_sample <= 1'b1;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        trace_count  <= '0;
        overflow     <= 1'b0;
        cycles_run   <= '0;
        halted       <= 1'b0;
      end else begin
        if (state == S_HOLD) hold_cnt <= hold_cnt + 32'd1;
        if (state == S_RUN) begin
          first_sample <= 1'b0;
          prev_sample  <= prog_out;
          stall_cnt    <= stall_next;
          budget_cnt   <= budget_cnt + 32'd1;
          if (cycles_run != 16'hFFFF) cycles_run <= cycles_run + 16'd1;
          if (halt_hit) halted <= 1'b1;
        end
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        case ({do_wr, do_rd})
          2'b10:   trace_count <= trace_count + 1'b1;
          2'b01:   trace_count <= trace_count - 1'b1;
          default: trace_count <= trace_count;
        endcase
        if (want_wr && !do_wr) overflow <= 1'b1;
      end
    end
  end

  // NOTE: trace storage is deliberately not reset; the pointers and count define which entries
  // are valid, and leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= prog_out;
  end

endmodule

// File: tb/tb_mcc_run_sequencer.sv
// Directed bench for mcc_run_sequencer: a default-parameter instance driven by a counting CPU
// model, and a change-capture instance driven by a fixed 5,5,7,7,7,9 output pattern.
module tb_mcc_run_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        start_a, rd_en_a, dut_reset_a, dut_run_a, rd_valid_a, overflow_a;
  logic        busy_a, done_a, halted_a;
  logic [15:0] prog_a, rd_data_a, cycles_run_a, cnt_a;
  logic [6:0]  trace_count_a;
  logic        mode_a;

  // Instance B: change capture, halt detection off, six-cycle budget
  logic        start_b, rd_en_b, dut_reset_b, dut_run_b, rd_valid_b, overflow_b;
  logic        busy_b, done_b, halted_b;
  logic [15:0] prog_b, rd_data_b, cycles_run_b, cnt_b;
  logic [6:0]  trace_count_b;

  int n_checks = 0;
  int n_errors = 0;

  mcc_run_sequencer u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .prog_out(prog_a),
    .dut_reset(dut_reset_a), .dut_run(dut_run_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .trace_count(trace_count_a), .overflow(overflow_a),
    .cycles_run(cycles_run_a), .busy(busy_a), .done(done_a), .halted(halted_a)
  );

  mcc_run_sequencer #(.RUN_CYCLES(6), .STALL_LIMIT(0), .CAPTURE_ON_CHANGE(1)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .prog_out(prog_b),
    .dut_reset(dut_reset_b), .dut_run(dut_run_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .trace_count(trace_count_b), .overflow(overflow_b),
    .cycles_run(cycles_run_b), .busy(busy_b), .done(done_b), .halted(halted_b)
  );

  // CPU models: a cycle counter cleared by dut_reset and advanced by dut_run.
  always @(posedge clock) begin
    if (dut_reset_a)    cnt_a <= 16'd0;
    else if (dut_run_a) cnt_a <= cnt_a + 16'd1;
    if (dut_reset_b)    cnt_b <= 16'd0;
    else if (dut_run_b) cnt_b <= cnt_b + 16'd1;
  end

  // mode_a=0: 0,1,2,...  mode_a=1: 1,2,3,3,3,...
  assign prog_a = !mode_a ? cnt_a : ((cnt_a < 16'd2) ? cnt_a + 16'd1 : 16'd3);

  always_comb begin
    prog_b = 16'd9;
    case (cnt_b)
      16'd0, 16'd1:        prog_b = 16'd5;
      16'd2, 16'd3, 16'd4: prog_b = 16'd7;
      default:             prog_b = 16'd9;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int n;
    reset = 1'b1; start_a = 1'b0; rd_en_a = 1'b0; mode_a = 1'b0;
    start_b = 1'b0; rd_en_b = 1'b0;
    repeat (2) tick();

    check("rst_dut_reset", 32'(dut_reset_a), 1);
    check("rst_dut_run", 32'(dut_run_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_count", 32'(trace_count_a), 0);
    check("rst_cycles", 32'(cycles_run_a), 0);
    check("rst_overflow", 32'(overflow_a), 0);
    check("rst_halted", 32'(halted_a), 0);
    check("rst_rd_valid", 32'(rd_valid_a), 0);
    reset = 1'b0;
    tick();

    rd_en_a = 1'b1; tick(); rd_en_a = 1'b0;
    check("empty_pop_valid", 32'(rd_valid_a), 0);
    check("empty_pop_count", 32'(trace_count_a), 0);

    // Sequence 1: full budget with incrementing output; start during RUN must be ignored.
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (busy_a && dut_reset_a && n < 50) begin n++; tick(); end
    check("s1_hold_len", n, 5);
    n = 0;
    while (dut_run_a && n < 1000) begin
      n++;
      start_a = (n == 50);
      tick();
    end
    start_a = 1'b0;
    check("s1_run_len", n, 296);
    check("s1_done", 32'(done_a), 1);
    check("s1_busy", 32'(busy_a), 0);
    check("s1_halted", 32'(halted_a), 0);
    check("s1_cycles", 32'(cycles_run_a), 296);
    check("s1_count", 32'(trace_count_a), 64);
    check("s1_overflow", 32'(overflow_a), 1);
    rd_en_a = 1'b1; tick(); rd_en_a = 1'b0;
    check("s1_pop_valid", 32'(rd_valid_a), 1);
    check("s1_pop_data", 32'(rd_data_a), 0);
    check("s1_pop_count", 32'(trace_count_a), 63);
    tick();
    check("s1_valid_pulse", 32'(rd_valid_a), 0);

    // Sequence 2: restart from DONE, read+write while full, then reset in the 100th RUN cycle.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("s2_dut_reset", 32'(dut_reset_a), 1);
    check("s2_busy", 32'(busy_a), 1);
    check("s2_count_clr", 32'(trace_count_a), 0);
    check("s2_overflow_clr", 32'(overflow_a), 0);
    check("s2_cycles_clr", 32'(cycles_run_a), 0);
    check("s2_halted_clr", 32'(halted_a), 0);
    check("s2_done_clr", 32'(done_a), 0);
    n = 0;
    while (busy_a && dut_reset_a && n < 50) begin n++; tick(); end
    check("s2_hold_len", n, 5);
    n = 0;
    while (trace_count_a != 7'd64 && n < 200) begin n++; tick(); end
    check("s2_fill_cycles", n, 64);
    check("s2_full_no_ovf", 32'(overflow_a), 0);
    rd_en_a = 1'b1; tick(); rd_en_a = 1'b0;
    check("s2_rw_full_count", 32'(trace_count_a), 64);
    check("s2_rw_full_valid", 32'(rd_valid_a), 1);
    check("s2_rw_full_data", 32'(rd_data_a), 0);
    check("s2_rw_full_ovf", 32'(overflow_a), 0);
    tick();
    check("s2_ovf_set", 32'(overflow_a), 1);
    check("s2_cycles_66", 32'(cycles_run_a), 66);
    repeat (33) tick();
    check("s2_cycles_99", 32'(cycles_run_a), 99);
    check("s2_still_run", 32'(dut_run_a), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("s2_rst_dut_reset", 32'(dut_reset_a), 1);
    check("s2_rst_dut_run", 32'(dut_run_a), 0);
    check("s2_rst_count", 32'(trace_count_a), 0);
    check("s2_rst_done", 32'(done_a), 0);
    check("s2_rst_busy", 32'(busy_a), 0);
    check("s2_rst_cycles", 32'(cycles_run_a), 0);

    // Sequence 3: output 1,2,3 then constant 3 -> halt after 11 samples.
    mode_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (busy_a && dut_reset_a && n < 50) begin n++; tick(); end
    check("s3_hold_len", n, 5);
    n = 0;
    while (dut_run_a && n < 1000) begin n++; tick(); end
    check("s3_run_len", n, 11);
    check("s3_cycles", 32'(cycles_run_a), 11);
    check("s3_halted", 32'(halted_a), 1);
    check("s3_done", 32'(done_a), 1);
    check("s3_count", 32'(trace_count_a), 11);

    // Instance B: change capture of 5,5,7,7,7,9.
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (busy_b && dut_reset_b && n < 50) begin n++; tick(); end
    check("b_hold_len", n, 5);
    n = 0;
    while (dut_run_b && n < 100) begin n++; tick(); end
    check("b_run_len", n, 6);
    check("b_done", 32'(done_b), 1);
    check("b_halted", 32'(halted_b), 0);
    check("b_count", 32'(trace_count_b), 3);
    check("b_overflow", 32'(overflow_b), 0);
    for (int i = 0; i < 3; i++) begin
      rd_en_b = 1'b1; tick(); rd_en_b = 1'b0;
      check("b_pop_valid", 32'(rd_valid_b), 1);
      check("b_pop_data", 32'(rd_data_b), (i == 0) ? 5 : (i == 1) ? 7 : 9);
      tick();
      check("b_valid_drop", 32'(rd_valid_b), 0);
    end
    check("b_empty_count", 32'(trace_count_b), 0);
    rd_en_b = 1'b1; tick(); rd_en_b = 1'b0;
    check("b_empty_pop", 32'(rd_valid_b), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
